// File: rtl/utf8_stream_decoder.sv
// Streaming UTF-8 to code-point decoder with a small registered output FIFO.
// Malformed, overlong and non-Unicode sequences are flagged per entry rather than dropped.
module utf8_stream_decoder #(
  parameter int DEPTH   = 4,
  parameter int LEGACY  = 0,
  parameter int REPLACE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 in_byte,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [30:0]                out_cp,
  output logic [2:0]                 out_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int unsigned RDY_MAX_I = DEPTH - 2;
  localparam logic [CW-1:0] RDY_MAX = CW'(RDY_MAX_I);

  typedef enum logic {IDLE, CONT} state_t;
  typedef struct packed {
    logic [30:0] cp;
    logic [2:0]  err;
  } entry_t;

  state_t        state, st_n;
  logic [2:0]    rem, rem_n, len, len_n;
  logic [30:0]   acc, acc_n, acc_sh, min_cp;
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  entry_t        ea, eb, head;
  logic          va, vb, take, flush_go, pop, cont_mode, overlong, nonuni;

  // Ready needs room for the worst case of two pushes in one cycle.
  assign in_ready   = (count <= RDY_MAX);
  assign take       = in_valid & in_ready;
  assign flush_go   = flush & in_ready;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign fifo_count = count;

  assign head    = mem[rd_ptr];
  assign out_err = head.err;
  assign out_cp  = (REPLACE != 0 && head.err != 3'b000) ? 31'h00FFFD : head.cp;

  assign acc_sh   = {acc[24:0], in_byte[5:0]};
  assign overlong = (acc_sh < min_cp);
  assign nonuni   = (acc_sh >= 31'h00D800 && acc_sh <= 31'h00DFFF) || (acc_sh > 31'h10FFFF);

  always_comb begin
    case (len)
      3'd2:    min_cp = 31'h0000080;
      3'd3:    min_cp = 31'h0000800;
      3'd4:    min_cp = 31'h0010000;
      3'd5:    min_cp = 31'h0200000;
      3'd6:    min_cp = 31'h4000000;
      default: min_cp = 31'h0;
    endcase
  end

  // Slot a carries an aborted partial sequence, slot b the decode of the current byte.
  always_comb begin
    st_n      = state;
    rem_n     = rem;
    len_n     = len;
    acc_n     = acc;
    va        = 1'b0;
    vb        = 1'b0;
    ea        = '0;
    eb        = '0;
    cont_mode = (state == CONT);
    if (flush_go && cont_mode) begin
      va        = 1'b1;
      ea        = '{cp: acc, err: 3'b001};
      cont_mode = 1'b0;
      st_n      = IDLE;
      rem_n     = '0;
      acc_n     = '0;
    end
    if (take) begin
      if (cont_mode && in_byte[7:6] == 2'b10) begin
        acc_n = acc_sh;
        rem_n = rem - 3'd1;
        if (rem == 3'd1) begin
          vb    = 1'b1;
          eb    = '{cp: acc_sh, err: {nonuni, overlong, 1'b0}};
          st_n  = IDLE;
          acc_n = '0;
        end
      end else begin
        if (cont_mode) begin
          va    = 1'b1;
          ea    = '{cp: acc, err: 3'b001};
          st_n  = IDLE;
          rem_n = '0;
          acc_n = '0;
        end
        if (!in_byte[7]) begin
          vb = 1'b1;
          eb = '{cp: 31'(in_byte), err: 3'b000};
        end else if (in_byte[7:5] == 3'b110) begin
          st_n = CONT; rem_n = 3'd1; len_n = 3'd2; acc_n = 31'(in_byte[4:0]);
        end else if (in_byte[7:4] == 4'b1110) begin
          st_n = CONT; rem_n = 3'd2; len_n = 3'd3; acc_n = 31'(in_byte[3:0]);
        end else if (in_byte[7:3] == 5'b11110) begin
          st_n = CONT; rem_n = 3'd3; len_n = 3'd4; acc_n = 31'(in_byte[2:0]);
        end else if (LEGACY != 0 && in_byte[7:2] == 6'b111110) begin
          st_n = CONT; rem_n = 3'd4; len_n = 3'd5; acc_n = 31'(in_byte[1:0]);
        end else if (LEGACY != 0 && in_byte[7:1] == 7'b1111110) begin
          st_n = CONT; rem_n = 3'd5; len_n = 3'd6; acc_n = 31'(in_byte[0]);
        end else begin
          vb = 1'b1;
          eb = '{cp: 31'(in_byte), err: 3'b001};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      len    <= '0;
      acc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= st_n;
      rem   <= rem_n;
      len   <= len_n;
      acc   <= acc_n;
      if (va) mem[wr_ptr] <= ea;
      if (vb) mem[va ? wr_ptr + AW'(1) : wr_ptr] <= eb;
      wr_ptr <= wr_ptr + AW'(va) + AW'(vb);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(va) + CW'(vb) - CW'(pop);
    end
  end
endmodule
